// File: rtl/sobel_edge_stage.sv
// sobel_edge_stage: 3x3 Sobel edge detector between the VGA scan generator and the DAC, fixed 4-cycle latency.
// Build option: define EDGE_OVERLAY_EN to overlay edges on the grayscale image instead of a binary edge map.
module sobel_edge_stage #(
    parameter int H_START  = 216,
    parameter int H_ACTIVE = 800,
    parameter int V_START  = 27,
    parameter int V_ACTIVE = 600,
    parameter int LAT      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] hcount,
    input  logic [10:0] vcount,
    input  logic        hs_in,
    input  logic        vs_in,
    input  logic [7:0]  pix_in,
    input  logic [7:0]  thresh,
    output logic [7:0]  pix_out,
    output logic        edge_out,
    output logic        de_out,
    output logic        hs_out,
    output logic        vs_out
);
    localparam logic [10:0] H_LO = 11'(H_START);
    localparam logic [10:0] H_HI = 11'(H_START + H_ACTIVE);
    localparam logic [10:0] V_LO = 11'(V_START);
    localparam logic [10:0] V_HI = 11'(V_START + V_ACTIVE);

    typedef enum logic {WAIT_SOF, RUN} state_t;

    state_t state_q, state_d;

    logic       sof;
    logic       active_in;
    logic       border_in;
    logic [9:0] x_in;
    logic [9:0] y_in;

    assign sof       = (hcount == 11'd0) && (vcount == 11'd0);
    assign active_in = (hcount >= H_LO) && (hcount < H_HI) && (vcount >= V_LO) && (vcount < V_HI);
    assign x_in      = 10'(hcount - H_LO);
    assign y_in      = 10'(vcount - V_LO);
    assign border_in = (x_in < 10'd2) || (y_in < 10'd2);

    // lb0 holds the previous line, lb1 the line before that
    logic [7:0] lb0_mem [H_ACTIVE];
    logic [7:0] lb1_mem [H_ACTIVE];

    logic [7:0]             thr_q, thr_d;
    logic                   s1_active_q, s1_active_d;
    logic                   s1_border_q, s1_border_d;
    logic [7:0]             s1_pix_q, s1_pix_d;
    logic [7:0]             s1_lb0_q, s1_lb0_d;
    logic [7:0]             s1_lb1_q, s1_lb1_d;
    logic [2:0][2:0][7:0]   win_q, win_d;
    logic                   s2_active_q, s2_active_d;
    logic                   s2_border_q, s2_border_d;
    logic signed [10:0]     gx_q, gx_d;
    logic signed [10:0]     gy_q, gy_d;
    logic                   s3_active_q, s3_active_d;
    logic                   s3_border_q, s3_border_d;
`ifdef EDGE_OVERLAY_EN
    logic [7:0]             s3_centre_q, s3_centre_d;
`endif
    logic [7:0]             pix_q, pix_d;
    logic                   edge_q, edge_d;
    logic                   de_q, de_d;
    logic [LAT-1:0]         hs_dly_q, hs_dly_d;
    logic [LAT-1:0]         vs_dly_q, vs_dly_d;

    function automatic logic [10:0] weighted_sum(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        return {3'b000, a} + {2'b00, b, 1'b0} + {3'b000, c};
    endfunction

    function automatic logic [10:0] abs11(input logic signed [10:0] g);
        return g[10] ? 11'(-g) : 11'(g);
    endfunction

    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_SOF: if (sof) state_d = RUN;
            RUN:      state_d = RUN;
            default:  state_d = WAIT_SOF;
        endcase
    end

    // Input capture and line-buffer read share the first register stage
    always_comb begin
        thr_d       = sof ? thresh : thr_q;
        s1_active_d = active_in;
        s1_border_d = border_in;
        s1_pix_d    = pix_in;
        s1_lb0_d    = s1_lb0_q;
        s1_lb1_d    = s1_lb1_q;
        if (active_in) begin
            s1_lb0_d = lb0_mem[x_in];
            s1_lb1_d = lb1_mem[x_in];
        end
        hs_dly_d = {hs_dly_q[LAT-2:0], hs_in};
        vs_dly_d = {vs_dly_q[LAT-2:0], vs_in};
    end

    // Window rows: 0 = two lines up, 1 = one line up, 2 = current; column 2 is the newest pixel
    always_comb begin
        win_d[0] = {s1_lb1_q, win_q[0][2], win_q[0][1]};
        win_d[1] = {s1_lb0_q, win_q[1][2], win_q[1][1]};
        win_d[2] = {s1_pix_q, win_q[2][2], win_q[2][1]};
        s2_active_d = s1_active_q;
        s2_border_d = s1_border_q;
    end

    always_comb begin
        gx_d = $signed(weighted_sum(win_q[0][2], win_q[1][2], win_q[2][2])
                     - weighted_sum(win_q[0][0], win_q[1][0], win_q[2][0]));
        gy_d = $signed(weighted_sum(win_q[2][0], win_q[2][1], win_q[2][2])
                     - weighted_sum(win_q[0][0], win_q[0][1], win_q[0][2]));
        s3_active_d = s2_active_q;
        s3_border_d = s2_border_q;
`ifdef EDGE_OVERLAY_EN
        s3_centre_d = win_q[1][1];
`endif
    end

    // Magnitude, saturation and threshold; borders and the first partial frame never flag edges
    always_comb begin
        logic [10:0] mag;
        logic [7:0]  sat;
        mag    = abs11(gx_q) + abs11(gy_q);
        sat    = (mag > 11'd255) ? 8'hFF : mag[7:0];
        if (s3_border_q) sat = 8'h00;
        edge_d = (state_q == RUN) && s3_active_q && !s3_border_q && (sat >= thr_q);
        de_d   = s3_active_q;
        pix_d  = 8'h00;
        if (s3_active_q) begin
`ifdef EDGE_OVERLAY_EN
            pix_d = edge_d ? 8'hFF : s3_centre_q;
`else
            pix_d = edge_d ? 8'hFF : 8'h00;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (active_in) begin
            lb0_mem[x_in] <= pix_in;
            lb1_mem[x_in] <= lb0_mem[x_in];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= WAIT_SOF;
            thr_q       <= '0;
            s1_active_q <= 1'b0;
            s1_border_q <= 1'b0;
            s1_pix_q    <= '0;
            s1_lb0_q    <= '0;
            s1_lb1_q    <= '0;
            win_q       <= '0;
            s2_active_q <= 1'b0;
            s2_border_q <= 1'b0;
            gx_q        <= '0;
            gy_q        <= '0;
            s3_active_q <= 1'b0;
            s3_border_q <= 1'b0;
`ifdef EDGE_OVERLAY_EN
            s3_centre_q <= '0;
`endif
            pix_q       <= '0;
            edge_q      <= 1'b0;
            de_q        <= 1'b0;
            hs_dly_q    <= '0;
            vs_dly_q    <= '0;
        end else begin
            state_q     <= state_d;
            thr_q       <= thr_d;
            s1_active_q <= s1_active_d;
            s1_border_q <= s1_border_d;
            s1_pix_q    <= s1_pix_d;
            s1_lb0_q    <= s1_lb0_d;
            s1_lb1_q    <= s1_lb1_d;
            win_q       <= win_d;
            s2_active_q <= s2_active_d;
            s2_border_q <= s2_border_d;
            gx_q        <= gx_d;
            gy_q        <= gy_d;
            s3_active_q <= s3_active_d;
            s3_border_q <= s3_border_d;
`ifdef EDGE_OVERLAY_EN
            s3_centre_q <= s3_centre_d;
`endif
            pix_q       <= pix_d;
            edge_q      <= edge_d;
            de_q        <= de_d;
            hs_dly_q    <= hs_dly_d;
            vs_dly_q    <= vs_dly_d;
        end
    end

    assign pix_out  = pix_q;
    assign edge_out = edge_q;
    assign de_out   = de_q;
    assign hs_out   = hs_dly_q[LAT-1];
    assign vs_out   = vs_dly_q[LAT-1];
endmodule

// File: tb/tb_sobel_edge_stage.sv
// tb_sobel_edge_stage: directed stimulus with a scoreboard of expected outputs, compared 4 cycles after drive.
// Expected pixels follow EDGE_OVERLAY_EN the same way the design does.
module tb_sobel_edge_stage;
    localparam int H_START  = 216;
    localparam int H_ACTIVE = 800;
    localparam int V_START  = 27;
    localparam int V_ACTIVE = 600;
    localparam int LAT      = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hs_in;
    logic        vs_in;
    logic [7:0]  pix_in;
    logic [7:0]  thresh;
    logic [7:0]  pix_out;
    logic        edge_out;
    logic        de_out;
    logic        hs_out;
    logic        vs_out;

    typedef struct {
        logic [11:0] val;
        logic [11:0] mask;
        int          h;
        int          v;
    } exp_t;

    exp_t       sb[$];
    int         errors = 0;
    int         checks = 0;
    bit         running;
    logic [7:0] thr_model;
    int         mode;
    int         blk_xs;
    int         blk_ys;

    always #5 clk = ~clk;

    sobel_edge_stage #(
        .H_START(H_START), .H_ACTIVE(H_ACTIVE), .V_START(V_START), .V_ACTIVE(V_ACTIVE), .LAT(LAT)
    ) dut (
        .clk(clk), .rst(rst), .hcount(hcount), .vcount(vcount), .hs_in(hs_in), .vs_in(vs_in),
        .pix_in(pix_in), .thresh(thresh), .pix_out(pix_out), .edge_out(edge_out),
        .de_out(de_out), .hs_out(hs_out), .vs_out(vs_out)
    );

    // All test images are row-invariant, so only the column matters
    function automatic int pat(input int m, input int x);
        case (m)
            1:       return (x < 400) ? 0 : 255;
            2:       return x % 256;
            default: return 128;
        endcase
    endfunction

    // Row-invariant image: Gy is zero and Gx = 4 * (right column - left column)
    function automatic int sobel_sat(input int m, input int cx);
        int gx;
        gx = 4 * (pat(m, cx + 1) - pat(m, cx - 1));
        if (gx < 0) gx = -gx;
        return (gx > 255) ? 255 : gx;
    endfunction

    function automatic logic [11:0] observed();
        return {hs_out, vs_out, de_out, edge_out, pix_out};
    endfunction

    task automatic check_obs(input string tag, input logic [11:0] obs, input logic [11:0] expv,
                             input logic [11:0] mask);
        checks++;
        assert ((obs & mask) === (expv & mask))
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h mask=%h", tag, obs, expv, mask);
        end
    endtask

    task automatic step(input int h, input int v, input int p);
        exp_t       e;
        int         x;
        int         y;
        bit         active;
        bit         interior;
        bit         valid_win;
        logic       edge_e;
        logic [7:0] pix_e;
        logic [11:0] mask;
        hcount = 11'(h);
        vcount = 11'(v);
        pix_in = 8'(p);
        hs_in  = (h >= 128);
        vs_in  = (v >= 4);
        if (h == 0 && v == 0) begin
            running   = 1'b1;
            thr_model = thresh;
        end
        x         = h - H_START;
        y         = v - V_START;
        active    = (h >= H_START) && (h < H_START + H_ACTIVE) && (v >= V_START) && (v < V_START + V_ACTIVE);
        interior  = (x >= 2) && (y >= 2);
        valid_win = (x >= blk_xs + 2) && (y >= blk_ys + 2);
        edge_e    = 1'b0;
        pix_e     = 8'h00;
        mask      = 12'hFFF;
        if (active) begin
            if (running && interior) begin
                if (valid_win) edge_e = (sobel_sat(mode, x - 1) >= int'(thr_model));
                else mask[8:0] = '0;
            end
`ifdef EDGE_OVERLAY_EN
            if (valid_win) pix_e = edge_e ? 8'hFF : 8'(pat(mode, x - 1));
            else mask[7:0] = '0;
`else
            pix_e = edge_e ? 8'hFF : 8'h00;
`endif
        end
        e.val  = {hs_in, vs_in, active, edge_e, pix_e};
        e.mask = mask;
        e.h    = h;
        e.v    = v;
        sb.push_back(e);
        @(negedge clk);
        if (sb.size() >= LAT) begin
            e = sb.pop_front();
            check_obs($sformatf("out h=%0d v=%0d", e.h, e.v), observed(), e.val, e.mask);
        end
    endtask

    // Reset asserted mid-cycle; the pipeline drains zeros for three cycles after release
    task automatic do_reset();
        exp_t z;
        #3 rst = 1'b1;
        #1 check_obs("reset async", observed(), 12'h000, 12'hFFF);
        sb.delete();
        running   = 1'b0;
        thr_model = 8'h00;
        @(negedge clk);
        check_obs("reset hold", observed(), 12'h000, 12'hFFF);
        @(negedge clk);
        check_obs("reset hold2", observed(), 12'h000, 12'hFFF);
        rst    = 1'b0;
        z.val  = 12'h000;
        z.mask = 12'hFFF;
        z.h    = -1;
        z.v    = -1;
        for (int i = 0; i < LAT - 1; i++) sb.push_back(z);
    endtask

    task automatic start_of_frame();
        for (int i = 0; i < 5; i++) step(1040 + i, 627, 0);
        step(0, 0, 0);
        for (int i = 1; i < 6; i++) step(i, 0, 0);
    endtask

    task automatic drive_block(input int xs, input int xe, input int ys, input int ye, input int m);
        mode   = m;
        blk_xs = xs;
        blk_ys = ys;
        for (int y = ys; y <= ye; y++) begin
            for (int x = xs; x <= xe; x++) step(H_START + x, V_START + y, pat(m, x));
            for (int i = 0; i < 4; i++) step(H_START + H_ACTIVE + i, V_START + y, 0);
        end
    endtask

    initial begin
        rst       = 1'b0;
        hcount    = '0;
        vcount    = '0;
        hs_in     = 1'b0;
        vs_in     = 1'b0;
        pix_in    = '0;
        thresh    = 8'h10;
        running   = 1'b0;
        thr_model = 8'h00;
        mode      = 0;
        blk_xs    = 0;
        blk_ys    = 0;

        do_reset();

        // Uniform image: no edges anywhere, including the x=0 and y=0 boundaries
        start_of_frame();
        drive_block(0, 9, 0, 3, 0);

        // Right edge of the active area: de must fall as hcount reaches 1016
        drive_block(796, 799, 0, 2, 0);

        // Vertical step edge, threshold 100
        thresh = 8'd100;
        start_of_frame();
        drive_block(395, 405, 0, 3, 1);

        // Reset mid-line: no edges until the next start of frame
        for (int x = 0; x < 6; x++) step(H_START + x, V_START + 10, pat(1, x));
        do_reset();
        for (int i = 0; i < 6; i++) step((i % 2 == 0) ? 10 : 300, 500, 0);
        drive_block(395, 405, 0, 3, 1);
        start_of_frame();
        drive_block(395, 405, 0, 3, 1);

        // Threshold sampled only at start of frame
        thresh = 8'hFF;
        start_of_frame();
        drive_block(100, 110, 0, 3, 2);
        thresh = 8'h01;
        drive_block(100, 110, 300, 303, 2);
        start_of_frame();
        drive_block(100, 110, 0, 3, 2);

        // Ramp magnitude is exactly 8
        thresh = 8'd8;
        start_of_frame();
        drive_block(100, 110, 0, 3, 2);
        thresh = 8'd9;
        start_of_frame();
        drive_block(100, 110, 0, 3, 2);

        // Vertical boundaries of the active area
        step(H_START + 5, V_START + V_ACTIVE, 0);
        step(H_START + 5, V_START - 1, 0);
        for (int i = 0; i < LAT; i++) step(1020, 627, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
